// File: rtl/c_ram_if.sv
// rtl/c_ram_if.sv - address, write-data and read-data bundle for the dual-port complex RAM
interface c_ram_if #(
    parameter int vector_size = 16,
    parameter int N           = 20
);
    localparam int AW = $clog2(N);

    logic [AW-1:0]          read_address1;
    logic [AW-1:0]          write_address1;
    logic [AW-1:0]          read_address2;
    logic [AW-1:0]          write_address2;
    logic                   wr_en;
    logic                   sel;
    logic [vector_size-1:0] in_real1;
    logic [vector_size-1:0] in_im1;
    logic [vector_size-1:0] in_real2;
    logic [vector_size-1:0] in_im2;
    logic [vector_size-1:0] out_real1;
    logic [vector_size-1:0] out_im1;
    logic [vector_size-1:0] out_real2;
    logic [vector_size-1:0] out_im2;

    modport master (
        output read_address1, write_address1, read_address2, write_address2,
        output wr_en, sel, in_real1, in_im1, in_real2, in_im2,
        input  out_real1, out_im1, out_real2, out_im2
    );

    modport slave (
        input  read_address1, write_address1, read_address2, write_address2,
        input  wr_en, sel, in_real1, in_im1, in_real2, in_im2,
        output out_real1, out_im1, out_real2, out_im2
    );
endinterface

// File: rtl/c_ram.sv
// rtl/c_ram.sv - dual-port complex-word RAM, 1-cycle registered reads, read-first by default
// Define CRAM_WR_FWD_EN to forward same-cycle write data to the read ports.
module c_ram #(
    parameter int vector_size = 16,
    parameter int N           = 20
) (
    input  logic   clk,
    input  logic   rst_n,
    c_ram_if.slave bus
);
    localparam int AW = $clog2(N);
    localparam int WW = 2 * vector_size;
    localparam logic [AW:0] DEPTH = (AW + 1)'(N);

    typedef logic [WW-1:0] word_t;

    word_t                  mem_q [N];
    word_t                  mem_d [N];
    logic [vector_size-1:0] out_real1_q, out_real1_d;
    logic [vector_size-1:0] out_im1_q,   out_im1_d;
    logic [vector_size-1:0] out_real2_q, out_real2_d;
    logic [vector_size-1:0] out_im2_q,   out_im2_d;

    logic  wr1_ok, wr2_ok, rd1_ok, rd2_ok;
    word_t rd1, rd2;

    always_comb begin
        wr1_ok = bus.wr_en && ({1'b0, bus.write_address1} < DEPTH);
        wr2_ok = bus.wr_en && bus.sel && ({1'b0, bus.write_address2} < DEPTH);
        rd1_ok = {1'b0, bus.read_address1} < DEPTH;
        rd2_ok = {1'b0, bus.read_address2} < DEPTH;

        // Port 2 is applied last so it wins a same-address collision.
        mem_d = mem_q;
        if (wr1_ok) mem_d[bus.write_address1] = {bus.in_real1, bus.in_im1};
        if (wr2_ok) mem_d[bus.write_address2] = {bus.in_real2, bus.in_im2};

        rd1 = '0;
        rd2 = '0;
`ifdef CRAM_WR_FWD_EN
        if (rd1_ok) rd1 = mem_d[bus.read_address1];
        if (rd2_ok) rd2 = mem_d[bus.read_address2];
`else
        if (rd1_ok) rd1 = mem_q[bus.read_address1];
        if (rd2_ok) rd2 = mem_q[bus.read_address2];
`endif

        out_real1_d = rd1[WW-1:vector_size];
        out_im1_d   = rd1[vector_size-1:0];
        out_real2_d = rd2[WW-1:vector_size];
        out_im2_d   = rd2[vector_size-1:0];
    end

    // Reset clears only the read registers; stored words survive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_real1_q <= '0;
            out_im1_q   <= '0;
            out_real2_q <= '0;
            out_im2_q   <= '0;
        end else begin
            mem_q       <= mem_d;
            out_real1_q <= out_real1_d;
            out_im1_q   <= out_im1_d;
            out_real2_q <= out_real2_d;
            out_im2_q   <= out_im2_d;
        end
    end

    assign bus.out_real1 = out_real1_q;
    assign bus.out_im1   = out_im1_q;
    assign bus.out_real2 = out_real2_q;
    assign bus.out_im2   = out_im2_q;
endmodule

// File: tb/tb_c_ram.sv
// tb/tb_c_ram.sv - table-driven bench for c_ram with a few hand-written timing sequences
module tb_c_ram;
    localparam int VS = 16;
    localparam int N  = 20;
    localparam int AW = $clog2(N);
`ifdef CRAM_WR_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    c_ram_if #(.vector_size(VS), .N(N)) bus ();
    c_ram #(.vector_size(VS), .N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic          rst_n, wr_en, sel;
        logic [AW-1:0] wa1, wa2, ra1, ra2;
        logic [VS-1:0] r1, i1, r2, i2;
        bit            chk;
        logic [VS-1:0] e_r1, e_i1, e_r2, e_i2;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(bit rs, bit we, bit s,
                                int wa1, int r1, int i1, int wa2, int r2, int i2,
                                int ra1, int ra2, bit chk,
                                int e_r1, int e_i1, int e_r2, int e_i2);
        vec_t v;
        v.rst_n = rs;  v.wr_en = we;  v.sel = s;
        v.wa1 = AW'(wa1); v.wa2 = AW'(wa2); v.ra1 = AW'(ra1); v.ra2 = AW'(ra2);
        v.r1 = VS'(r1); v.i1 = VS'(i1); v.r2 = VS'(r2); v.i2 = VS'(i2);
        v.chk = chk;
        v.e_r1 = VS'(e_r1); v.e_i1 = VS'(e_i1); v.e_r2 = VS'(e_r2); v.e_i2 = VS'(e_i2);
        return v;
    endfunction

    task automatic check(string name, logic [VS-1:0] act, logic [VS-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        rst_n              = v.rst_n;
        bus.wr_en          = v.wr_en;
        bus.sel            = v.sel;
        bus.write_address1 = v.wa1;
        bus.write_address2 = v.wa2;
        bus.read_address1  = v.ra1;
        bus.read_address2  = v.ra2;
        bus.in_real1 = v.r1; bus.in_im1 = v.i1;
        bus.in_real2 = v.r2; bus.in_im2 = v.i2;
    endtask

    task automatic check4(string tag, int e_r1, int e_i1, int e_r2, int e_i2);
        check({tag, ".out_real1"}, bus.out_real1, VS'(e_r1));
        check({tag, ".out_im1"},   bus.out_im1,   VS'(e_i1));
        check({tag, ".out_real2"}, bus.out_real2, VS'(e_r2));
        check({tag, ".out_im2"},   bus.out_im2,   VS'(e_i2));
    endtask

    initial begin
        //           rs we s  wa1 r1    i1    wa2 r2    i2    ra1 ra2 chk  expected r1/i1/r2/i2
        vecs.push_back(mk(0, 0, 0,  0, 0,    0,    0,  0,    0,    0,  0,  1,   0,    0,    0,    0));
        vecs.push_back(mk(1, 1, 1,  7, 'hA,  'hB,  8,  'hC,  'hD,  0,  0,  0,   0,    0,    0,    0));
        vecs.push_back(mk(1, 1, 1,  0, 1,    0,    1,  3,    2,    7,  8,  1,   'hA,  'hB,  'hC,  'hD));
        vecs.push_back(mk(1, 0, 0,  0, 0,    0,    0,  0,    0,    1,  0,  1,   3,    2,    1,    0));
        vecs.push_back(mk(1, 1, 0,  4, 5,    6,    7,  9,    9,    0,  1,  1,   1,    0,    3,    2));
        vecs.push_back(mk(1, 0, 0,  0, 0,    0,    0,  0,    0,    4,  7,  1,   5,    6,    'hA,  'hB));
        vecs.push_back(mk(1, 1, 1,  3, 'h11, 'h22, 3,  'h33, 'h44, 4,  4,  1,   5,    6,    5,    6));
        vecs.push_back(mk(1, 0, 0,  0, 0,    0,    0,  0,    0,    3,  3,  1,   'h33, 'h44, 'h33, 'h44));
        vecs.push_back(mk(1, 1, 0,  5, 7,    7,    0,  0,    0,    0,  1,  1,   1,    0,    3,    2));
        vecs.push_back(mk(1, 1, 0,  5, 8,    8,    0,  0,    0,    5,  3,  1,
                          FWD ? 8 : 7, FWD ? 8 : 7, 'h33, 'h44));
        vecs.push_back(mk(1, 0, 0,  0, 0,    0,    0,  0,    0,    5,  5,  1,   8,    8,    8,    8));
        vecs.push_back(mk(1, 1, 1,  3, 'h55, 'h55, 3,  'h66, 'h66, 3,  0,  1,
                          FWD ? 'h66 : 'h33, FWD ? 'h66 : 'h44, 1, 0));
        vecs.push_back(mk(1, 0, 0,  0, 0,    0,    0,  0,    0,    3,  3,  1,   'h66, 'h66, 'h66, 'h66));
        vecs.push_back(mk(1, 1, 1, 25, 'hEE, 'hEE, 25, 'hEE, 'hEE, 25, 0,  1,   0,    0,    1,    0));
        vecs.push_back(mk(1, 0, 0,  0, 0,    0,    0,  0,    0,    25, 25, 1,   0,    0,    0,    0));
        vecs.push_back(mk(1, 0, 0,  0, 0,    0,    0,  0,    0,    5,  4,  1,   8,    8,    5,    6));
        vecs.push_back(mk(0, 1, 1,  0, 'hFF, 'hFF, 1,  'hFF, 'hFF, 4,  5,  1,   0,    0,    0,    0));
        vecs.push_back(mk(1, 0, 0,  0, 0,    0,    0,  0,    0,    0,  1,  1,   1,    0,    3,    2));

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k]);
            @(posedge clk);
            #1;
            if (vecs[k].chk)
                check4($sformatf("vec%0d", k), vecs[k].e_r1, vecs[k].e_i1, vecs[k].e_r2, vecs[k].e_i2);
        end

        // Outputs must hold between edges even when the read address changes.
        bus.wr_en = 1'b0;
        bus.read_address1 = AW'(7);
        bus.read_address2 = AW'(8);
        @(posedge clk);
        #1;
        check4("hold_pre", 'hA, 'hB, 'hC, 'hD);
        bus.read_address1 = AW'(0);
        bus.read_address2 = AW'(4);
        #3;
        check4("hold_mid", 'hA, 'hB, 'hC, 'hD);
        @(posedge clk);
        #1;
        check4("hold_post", 1, 0, 5, 6);

        // Back-to-back write then read of a fresh address.
        bus.wr_en = 1'b1;
        bus.sel   = 1'b0;
        bus.write_address1 = AW'(9);
        bus.in_real1 = VS'('h99);
        bus.in_im1   = VS'('h98);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.read_address1 = AW'(9);
        bus.read_address2 = AW'(9);
        @(posedge clk);
        #1;
        check4("wr_then_rd", 'h99, 'h98, 'h99, 'h98);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/c_ram.md
C_RAM -- requirements
Module: c_ram

Interface
REQ-001 Parameter vector_size, default 16: bit width of each real and each imaginary component.
REQ-002 Parameter N, default 20: depth in complex words; N >= 2; AW = ceil(log2 N) (5 for N=20).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 read_address1  input  AW  port-1 read address.
REQ-006 write_address1  input  AW  port-1 write address.
REQ-007 read_address2  input  AW  port-2 read address.
REQ-008 write_address2  input  AW  port-2 write address.
REQ-009 wr_en  input  1  global write enable.
REQ-010 sel  input  1  port-2 write enable qualifier; 1 = both ports write, 0 = only port 1 writes.
REQ-011 in_real1, in_im1  input  vector_size each  port-1 write data.
REQ-012 in_real2, in_im2  input  vector_size each  port-2 write data.
REQ-013 out_real1, out_im1  output  vector_size each  port-1 registered read data.
REQ-014 out_real2, out_im2  output  vector_size each  port-2 registered read data.

Function
REQ-015 Storage: N entries, each holding a real and an imaginary word of vector_size bits.
REQ-016 Port-1 write: at a rising edge with rst_n=1 and wr_en=1, mem[write_address1] <= {in_real1, in_im1}.
REQ-017 Port-2 write: at a rising edge with rst_n=1, wr_en=1 and sel=1, mem[write_address2] <= {in_real2, in_im2}.
REQ-018 With wr_en=0, no write occurs, regardless of sel.
REQ-019 Both reads run every cycle with rst_n=1: out_*1 <= mem[read_address1] and out_*2 <= mem[read_address2]; read latency is 1 cycle; outputs hold between edges.
REQ-020 Write collision: if both ports write the same address in one cycle, port 2's data is stored.
REQ-021 Read-during-write to the same address, default behaviour: read returns the old contents (read-first); see REQ-027.
REQ-022 Out-of-range address (>= N): writes to it are dropped with no aliasing; reads from it return 0.
REQ-023 Both read ports may use the same address; both then return the identical word.

Reset
REQ-024 While rst_n=0 at a rising edge, all four outputs become 0 and no write occurs.
REQ-025 Reset does not clear memory contents; entries written before reset are preserved.
REQ-026 Before any write, memory contents are undefined; verification only checks written entries.

Configuration
REQ-027 Macro CRAM_WR_FWD_EN: when defined, a read whose address equals an address written in the same cycle returns the new data, with the port-2 value winning per REQ-020. When not defined, REQ-021 read-first behaviour applies.

Verification
REQ-028 Dual write: wr_en=1, sel=1, wa1=0 writes {1,0}, wa2=1 writes {3,2}; next cycle wr_en=0, ra1=1, ra2=0 -> one edge later out_real1=3, out_im1=2, out_real2=1, out_im2=0.
REQ-029 sel=0: wr_en=1, wa1=4 writes {5,6}, wa2=7 writes {9,9}; then read ra1=4, ra2=7 -> port 1 returns {5,6}; port 2 returns the prior contents of address 7, not {9,9}.
REQ-030 Collision: wa1=wa2=3, data {0x11,0x22} on port 1 and {0x33,0x44} on port 2, sel=1 -> a later read of address 3 returns {0x33,0x44}.
REQ-031 Read-during-write: address 5 holds {7,7}; write {8,8} to address 5 while ra1=5 -> out_real1=7, out_im1=7 without the macro, 8/8 with CRAM_WR_FWD_EN; the next cycle reads 8/8 in both builds.
REQ-032 Reset and range: rst_n=0 for one edge -> all outputs 0 and address 0 still reads {1,0} after reset; a write to address 25 is dropped and a read of address 25 returns 0.
